vc_arbiter: RTL and testbench

VC_ARBITER -- requirements
Module: vc_arbiter

---
 rtl/vc_arbiter.sv | 137 +++++++++++++
 tb/tb_vc_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted round-robin arbiter between two virtual-channel FIFOs.
// Each VC gets up to weight_vcN consecutive pops per turn. It only pops while
// its head word's destination is not paused. A turn whose credit runs out with
// no competitor is renewed, so the arbiter never idles while work is waiting.
// Optional feature: define VC_ARB_STATS_EN to add saturating 8-bit grant
// counters (grant_cnt_vc0/grant_cnt_vc1).
module vc_arbiter #(
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] weight_vc0,
  input  logic [WEIGHT_W-1:0] weight_vc1,
  input  logic                vc0_empty,
  input  logic                vc1_empty,
  input  logic                vc0_head_dest,
  input  logic                vc1_head_dest,
  input  logic                pause_d0,
  input  logic                pause_d1,
  output logic                pop_vc0,
  output logic                pop_vc1,
  output logic                valid_out,
  output logic                grant_vc,
  output logic [1:0]          arb_state
`ifdef VC_ARB_STATS_EN
  ,
  output logic [7:0]          grant_cnt_vc0,
  output logic [7:0]          grant_cnt_vc1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_t;

  localparam logic [WEIGHT_W-1:0] ONE = WEIGHT_W'(1);

  state_t                     state, state_nxt;
  logic [1:0][WEIGHT_W-1:0]   cred, cred_nxt;   // remaining pops in the current turn, per VC
  logic [1:0][WEIGHT_W-1:0]   wgt;              // latched weights, never 0
  logic [1:0]                 elig, pop;
  logic                       cur, oth;

  // A VC is eligible when it has data and its head word's destination has room.
  assign elig[0] = !vc0_empty && !(vc0_head_dest ? pause_d1 : pause_d0);
  assign elig[1] = !vc1_empty && !(vc1_head_dest ? pause_d1 : pause_d0);

  assign pop_vc0   = pop[0];
  assign pop_vc1   = pop[1];
  assign arb_state = state;

  // Next-state, credit bookkeeping and combinational pop strobes.
  always_comb begin
    state_nxt = state;
    cred_nxt  = cred;
    pop       = '0;
    cur       = (state == SERVE1);
    oth       = !cur;
    if (init) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (elig[0]) begin
            state_nxt   = SERVE0;
            cred_nxt[0] = wgt[0];
          end else if (elig[1]) begin
            state_nxt   = SERVE1;
            cred_nxt[1] = wgt[1];
          end
        end
        SERVE0, SERVE1: begin
          if (elig[cur]) begin
            pop[cur] = 1'b1;
            if (cred[cur] > ONE) begin
              cred_nxt[cur] = cred[cur] - ONE;
            end else if (elig[oth]) begin
              // Turn exhausted and the other VC is waiting: hand over.
              state_nxt     = oth ? SERVE1 : SERVE0;
              cred_nxt[oth] = wgt[oth];
            end else begin
              // Turn exhausted but nobody else wants it: renew in place.
              cred_nxt[cur] = wgt[cur];
            end
          end else if (elig[oth]) begin
            state_nxt     = oth ? SERVE1 : SERVE0;
            cred_nxt[oth] = wgt[oth];
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;   // 2'b11 is unused; recover without popping
      endcase
    end
  end

  // State, credits, latched weights and the one-cycle-delayed grant report.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      cred      <= {2{ONE}};
      wgt       <= {2{ONE}};
      valid_out <= 1'b0;
      grant_vc  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cred      <= cred_nxt;
      valid_out <= |pop;
      grant_vc  <= pop[1];
      if (init) begin
        // A zero weight would starve the VC; treat it as one pop per turn.
        wgt[0] <= (weight_vc0 == '0) ? ONE : weight_vc0;
        wgt[1] <= (weight_vc1 == '0) ? ONE : weight_vc1;
      end
    end
  end

`ifdef VC_ARB_STATS_EN
  // Saturating per-VC grant counters, cleared by reset or init.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grant_cnt_vc0 <= '0;
      grant_cnt_vc1 <= '0;
    end else if (init) begin
      grant_cnt_vc0 <= '0;
      grant_cnt_vc1 <= '0;
    end else begin
      if (pop[0] && grant_cnt_vc0 != 8'hFF) grant_cnt_vc0 <= grant_cnt_vc0 + 8'd1;
      if (pop[1] && grant_cnt_vc1 != 8'hFF) grant_cnt_vc1 <= grant_cnt_vc1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed-vector bench for vc_arbiter with hand-computed
// expectations. Inputs change 1 time unit after the rising edge; outputs are
// sampled a further unit later, well away from the next edge.
module tb_vc_arbiter;

  logic       clk, reset_L, init;
  logic [3:0] weight_vc0, weight_vc1;
  logic       vc0_empty, vc1_empty, vc0_head_dest, vc1_head_dest;
  logic       pause_d0, pause_d1;
  logic       pop_vc0, pop_vc1, valid_out, grant_vc;
  logic [1:0] arb_state;
`ifdef VC_ARB_STATS_EN
  logic [7:0] grant_cnt_vc0, grant_cnt_vc1;
`endif

  int         n_chk, n_err;
  logic [7:0] seq;
  logic       exp_p1;

  vc_arbiter #(.WEIGHT_W(4)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .weight_vc0(weight_vc0), .weight_vc1(weight_vc1),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_head_dest(vc0_head_dest), .vc1_head_dest(vc1_head_dest),
    .pause_d0(pause_d0), .pause_d1(pause_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .valid_out(valid_out), .grant_vc(grant_vc), .arb_state(arb_state)
`ifdef VC_ARB_STATS_EN
    , .grant_cnt_vc0(grant_cnt_vc0), .grant_cnt_vc1(grant_cnt_vc1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; reset_L = 0; init = 0;
    weight_vc0 = 0; weight_vc1 = 0;
    vc0_empty = 1; vc1_empty = 1; vc0_head_dest = 0; vc1_head_dest = 0;
    pause_d0 = 0; pause_d1 = 0;
    n_chk = 0; n_err = 0;

    // Reset state
    #3;
    chk("rst_state", arb_state, 2'b00);
    chk("rst_pops", {pop_vc0, pop_vc1}, 2'b00);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_grant", grant_vc, 1'b0);

    // Weights 3/1, both always eligible: 0,0,0,1 repeating
    step(); step();
    reset_L = 1; init = 1; weight_vc0 = 4'd3; weight_vc1 = 4'd1;
    vc0_empty = 0; vc1_empty = 0;
    #1;
    chk("init_no_pop", {pop_vc0, pop_vc1}, 2'b00);
    step(); init = 0; #1;
    chk("idle_state", arb_state, 2'b00);
    chk("idle_no_pop", {pop_vc0, pop_vc1}, 2'b00);
    seq = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      exp_p1 = seq[i];
      chk($sformatf("w31_state%0d", i), arb_state, exp_p1 ? 2'b10 : 2'b01);
      chk($sformatf("w31_pops%0d", i), {pop_vc0, pop_vc1}, {!exp_p1, exp_p1});
      chk($sformatf("w31_valid%0d", i), valid_out, (i > 0));
      chk($sformatf("w31_grant%0d", i), grant_vc, (i > 0) ? seq[i-1] : 1'b0);
    end

    // Weights 2/2, vc1 empty: vc0 pops every cycle, credit renewed
    init = 1; weight_vc0 = 4'd2; weight_vc1 = 4'd2; vc1_empty = 1; #1;
    chk("init2_no_pop", {pop_vc0, pop_vc1}, 2'b00);
    step(); init = 0; #1;
    chk("init2_idle", arb_state, 2'b00);
    chk("init2_valid", valid_out, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk($sformatf("w22_state%0d", i), arb_state, 2'b01);
      chk($sformatf("w22_pops%0d", i), {pop_vc0, pop_vc1}, 2'b10);
    end

    // Pause on vc0's destination suppresses its pop at once; switch to vc1
    vc1_empty = 0; vc1_head_dest = 0; vc0_head_dest = 1; pause_d1 = 1; #1;
    chk("pause_pops", {pop_vc0, pop_vc1}, 2'b00);
    chk("pause_state", arb_state, 2'b01);
    step(); #1;
    chk("pause_next_state", arb_state, 2'b10);
    chk("pause_next_pops", {pop_vc0, pop_vc1}, 2'b01);
    chk("pause_next_valid", valid_out, 1'b0);

    // Reset mid-turn with credit 2 left
    pause_d1 = 0; vc0_head_dest = 0;
    init = 1; weight_vc0 = 4'd3; weight_vc1 = 4'd1;
    step(); init = 0;
    step();           // SERVE0, credit 3, pop
    step(); #1;       // SERVE0, credit 2, pop
    chk("mid_state", arb_state, 2'b01);
    chk("mid_pops", {pop_vc0, pop_vc1}, 2'b10);
    reset_L = 0; #1;
    chk("async_rst_state", arb_state, 2'b00);
    chk("async_rst_pops", {pop_vc0, pop_vc1}, 2'b00);
    chk("async_rst_valid", valid_out, 1'b0);
    chk("async_rst_grant", grant_vc, 1'b0);
    step(); reset_L = 1; #1;
    chk("post_rst_idle", arb_state, 2'b00);
    step(); #1;
    chk("post_rst_serve0", arb_state, 2'b01);
    chk("post_rst_pop", {pop_vc0, pop_vc1}, 2'b10);
    step(); #1;   // latched weights were reset to 1: one pop then hand over
    chk("post_rst_serve1", arb_state, 2'b10);

    // Weight 0 treated as 1: strict alternation with weight_vc1 = 1
    init = 1; weight_vc0 = 4'd0; weight_vc1 = 4'd1;
    step(); init = 0;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk($sformatf("w0_state%0d", i), arb_state, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("w0_pops%0d", i), {pop_vc0, pop_vc1}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Neither eligible while serving: no pop this cycle, IDLE next
    vc0_empty = 1; vc1_empty = 1; #1;
    chk("none_pops", {pop_vc0, pop_vc1}, 2'b00);
    step(); #1;
    chk("none_idle", arb_state, 2'b00);
    chk("none_valid", valid_out, 1'b0);

`ifdef VC_ARB_STATS_EN
    // Grant counters saturate at 255 and clear on init
    init = 1; step(); init = 0; #1;
    chk("cnt_clear0", grant_cnt_vc0, 8'd0);
    vc0_empty = 0;
    for (int i = 0; i < 301; i++) step();
    chk("cnt_sat_vc0", grant_cnt_vc0, 8'd255);
    chk("cnt_vc1_zero", grant_cnt_vc1, 8'd0);
    init = 1; step(); init = 0; #1;
    chk("cnt_init_vc0", grant_cnt_vc0, 8'd0);
    chk("cnt_init_vc1", grant_cnt_vc1, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Watchdog so the bench always terminates on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
